pipeline_ctrl: RTL and testbench

Sequencer for the five-stage pipeline's register enables and flushes. It arbitrates between the hazard-detection stall, instruction-cache and data-cache miss stalls, and ID-stage branch-mispredict redirects. It holds a redirect that arrives during an in-flight I-cache miss until the fetch completes, and keeps saturating stall and flush statistics. It sits between the hazard unit, both caches, and the PC and pipeline-register write controls.

---
 rtl/pipeline_ctrl_pkg.sv | 36 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state, per-cycle cause, and the priority decode.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        DFREEZE = 3'd1,
        PEND    = 3'd2,
        HAZARD  = 3'd3,
        MISPRED = 3'd4,
        IFETCH  = 3'd5
    } cause_t;

    // First match wins: a D-cache freeze outranks even a pending redirect.
    function automatic cause_t decode_cause(
        input logic dcache_stall,
        input logic pend,
        input logic hazard_stall,
        input logic br_mispredict,
        input logic icache_stall
    );
        cause_t c;
        if (dcache_stall)       c = DFREEZE;
        else if (pend)          c = PEND;
        else if (hazard_stall)  c = HAZARD;
        else if (br_mispredict) c = MISPRED;
        else if (icache_stall)  c = IFETCH;
        else                    c = NONE;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects inc one edge later; no backpressure.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline enable/flush sequencer arbitrating D-cache freeze, hazard, mispredict and I-cache stalls.
// Latency: enables/flushes/redirect are combinational (zero cycle); a redirect held behind an I-cache miss issues when fetch completes.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hazard_stall,
    input  logic          icache_stall,
    input  logic          dcache_stall,
    input  logic          br_mispredict,
    input  logic [AW-1:0] br_target,
    output logic          pc_we,
    output logic          pc_sel_redirect,
    output logic [AW-1:0] pc_redirect_addr,
    output logic          ifid_we,
    output logic          idex_we,
    output logic          exmem_we,
    output logic          memwb_we,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pend_addr_q;
    logic [AW-1:0] pend_addr_d;
    cause_t        cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign cause = decode_cause(dcache_stall, state_q == REDIR_WAIT,
                                hazard_stall, br_mispredict, icache_stall);

    always_comb begin
        state_d          = state_q;
        pend_addr_d      = pend_addr_q;
        pc_we            = 1'b0;
        pc_sel_redirect  = 1'b0;
        pc_redirect_addr = '0;
        ifid_we          = 1'b0;
        idex_we          = 1'b0;
        exmem_we         = 1'b0;
        memwb_we         = 1'b0;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;

        // Outputs are forced quiet for the whole time reset is asserted.
        if (rst_n) begin
            unique case (cause)
                DFREEZE: begin
                    // Full freeze: all enables already low, state held.
                end
                PEND: begin
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    if (!icache_stall) begin
                        pc_we            = 1'b1;
                        pc_sel_redirect  = 1'b1;
                        pc_redirect_addr = pend_addr_q;
                        state_d          = RUN;
                    end
                end
                HAZARD, IFETCH: begin
                    idex_flush = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                end
                MISPRED: begin
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    if (icache_stall) begin
                        // Fetch address must stay stable; park the target until the miss ends.
                        pend_addr_d = br_target;
                        state_d     = REDIR_WAIT;
                    end else begin
                        pc_we            = 1'b1;
                        pc_sel_redirect  = 1'b1;
                        pc_redirect_addr = br_target;
                    end
                end
                default: begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rst_n & ~pc_we),
        .count (stall_cnt)
    );

    sat_counter #(.CW(CW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_sel_redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a per-cycle reference model and literal spot checks.
module tb_pipeline_ctrl;

    localparam int AW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          hazard_stall;
    logic          icache_stall;
    logic          dcache_stall;
    logic          br_mispredict;
    logic [AW-1:0] br_target;
    logic          pc_we;
    logic          pc_sel_redirect;
    logic [AW-1:0] pc_redirect_addr;
    logic          ifid_we;
    logic          idex_we;
    logic          exmem_we;
    logic          memwb_we;
    logic          ifid_flush;
    logic          idex_flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.AW(AW), .CW(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazard_stall     (hazard_stall),
        .icache_stall     (icache_stall),
        .dcache_stall     (dcache_stall),
        .br_mispredict    (br_mispredict),
        .br_target        (br_target),
        .pc_we            (pc_we),
        .pc_sel_redirect  (pc_sel_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .ifid_we          (ifid_we),
        .idex_we          (idex_we),
        .exmem_we         (exmem_we),
        .memwb_we         (memwb_we),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending-redirect flag/address plus plain integer counters.
    bit          m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_scnt = 0;
    int          m_fcnt = 0;

    // Control bits ordered {pc_we, sel, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
    always @(negedge clk) begin
        logic [7:0]  e;
        logic [31:0] ea;
        e  = 8'b0;
        ea = '0;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_addr = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else if (dcache_stall) begin
            e = 8'b0000_0000;
        end else if (m_pend) begin
            e = icache_stall ? 8'b0001_1110 : 8'b1101_1110;
            if (!icache_stall) ea = m_addr;
        end else if (hazard_stall) begin
            e = 8'b0000_1101;
        end else if (br_mispredict) begin
            e = icache_stall ? 8'b0001_1110 : 8'b1101_1110;
            if (!icache_stall) ea = br_target;
        end else if (icache_stall) begin
            e = 8'b0000_1101;
        end else begin
            e = 8'b1011_1100;
        end

        chk("ctl", {24'b0, pc_we, pc_sel_redirect, ifid_we, idex_we, exmem_we, memwb_we,
                    ifid_flush, idex_flush}, {24'b0, e});
        chk("redirect_addr", pc_redirect_addr, ea);
        chk("stall_cnt", {28'b0, stall_cnt}, m_scnt);
        chk("flush_cnt", {28'b0, flush_cnt}, m_fcnt);

        if (rst_n) begin
            if (!e[7] && m_scnt < CMAX) m_scnt++;
            if (e[6] && m_fcnt < CMAX) m_fcnt++;
            if (!dcache_stall) begin
                if (m_pend) begin
                    if (!icache_stall) m_pend = 1'b0;
                end else if (!hazard_stall && br_mispredict && icache_stall) begin
                    m_pend = 1'b1;
                    m_addr = br_target;
                end
            end
        end
    end

    // One cycle of stimulus; returns just after the falling edge so literal checks see settled outputs.
    task automatic cyc(input bit hz, input bit ic, input bit dc, input bit bm, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        hazard_stall  = hz;
        icache_stall  = ic;
        dcache_stall  = dc;
        br_mispredict = bm;
        br_target     = tgt;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        hazard_stall  = 1'b0;
        icache_stall  = 1'b0;
        dcache_stall  = 1'b0;
        br_mispredict = 1'b0;
        br_target     = '0;
        @(negedge clk);
        #1;
        chk("rst_pc_we", {31'b0, pc_we}, 32'd0);
        chk("rst_ifid_we", {31'b0, ifid_we}, 32'd0);
        chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 32'h0);
        chk("idle_ifid_we", {31'b0, ifid_we}, 32'd1);
        chk("idle_memwb_we", {31'b0, memwb_we}, 32'd1);
        chk("idle_stall_cnt", {28'b0, stall_cnt}, 32'd0);

        cyc(1, 0, 0, 0, 32'h0);
        chk("hz_pc_we", {31'b0, pc_we}, 32'd0);
        chk("hz_idex_flush", {31'b0, idex_flush}, 32'd1);
        chk("hz_exmem_we", {31'b0, exmem_we}, 32'd1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("hz_stall_cnt", {28'b0, stall_cnt}, 32'd1);

        cyc(0, 0, 0, 1, 32'h0040_0100);
        chk("bm_sel", {31'b0, pc_sel_redirect}, 32'd1);
        chk("bm_addr", pc_redirect_addr, 32'h0040_0100);
        chk("bm_ifid_flush", {31'b0, ifid_flush}, 32'd1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("bm_flush_cnt", {28'b0, flush_cnt}, 32'd1);

        // Mispredict behind an I-cache miss; later target changes must be ignored.
        cyc(0, 1, 0, 1, 32'h0040_0200);
        chk("pend_pc_we", {31'b0, pc_we}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'hDEAD_BEEC);
        chk("pend_ifid_flush", {31'b0, ifid_flush}, 32'd1);
        cyc(0, 0, 0, 0, 32'hDEAD_BEEC);
        chk("pend_addr", pc_redirect_addr, 32'h0040_0200);
        cyc(0, 0, 0, 0, 32'h0);
        chk("pend_stall_cnt", {28'b0, stall_cnt}, 32'd5);
        chk("pend_flush_cnt", {28'b0, flush_cnt}, 32'd2);

        // Pending redirect delayed by a two-cycle D-cache freeze.
        cyc(0, 1, 0, 1, 32'h0040_0300);
        cyc(0, 1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0);
        chk("dfrz_pc_we", {31'b0, pc_we}, 32'd0);
        chk("dfrz_memwb_we", {31'b0, memwb_we}, 32'd0);
        cyc(0, 0, 1, 1, 32'h0);
        chk("dfrz_sel", {31'b0, pc_sel_redirect}, 32'd0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("dfrz_addr", pc_redirect_addr, 32'h0040_0300);

        // Freeze with I-cache miss and mispredict in RUN: nothing latched.
        cyc(0, 1, 1, 1, 32'h0040_0500);
        cyc(0, 0, 0, 0, 32'h0);
        chk("both_sel", {31'b0, pc_sel_redirect}, 32'd0);
        chk("both_pc_we", {31'b0, pc_we}, 32'd1);

        // Reset in REDIR_WAIT drops the pending redirect.
        cyc(0, 1, 0, 1, 32'h0040_0400);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        icache_stall  = 1'b0;
        br_mispredict = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_pc_we", {31'b0, pc_we}, 32'd0);
        chk("midrst_flush_cnt", {28'b0, flush_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("postrst_sel", {31'b0, pc_sel_redirect}, 32'd0);
        chk("postrst_pc_we", {31'b0, pc_we}, 32'd1);

        // Pending redirect outranks a hazard stall.
        cyc(0, 1, 0, 1, 32'h0040_0600);
        cyc(1, 1, 0, 1, 32'h0);
        cyc(1, 0, 0, 0, 32'h0);
        chk("pendhz_addr", pc_redirect_addr, 32'h0040_0600);

        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("sat_stall_cnt", {28'b0, stall_cnt}, 32'd15);

        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 32'h0000_1000 + 32'(i * 4));
        cyc(0, 0, 0, 0, 32'h0);
        chk("sat_flush_cnt", {28'b0, flush_cnt}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
